instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream stage of the control unit: fetches 16-bit instructions from program memory over a req/ack handshake.
//  Buffers them in a small prefetch FIFO and presents one instruction, stable for the unit's 4-cycle execute
//  sequence (states 00..11). Mirrors that 2-bit state in an internal phase counter.
//  Drives cu_hold; the core ANDs it into the control unit reset (core_resetn = resetn & ~cu_hold).
//  This freezes the control unit at state 00 whenever no instruction is ready.
// PARAMETERS
//  ADDR_W      8   program address width; fetch PC wraps modulo 2**ADDR_W
//  DEPTH       2   prefetch FIFO entries (power of two, >=2)
//  START_ADDR  0   fetch address after reset
// PORTS
//  clock          in   1       rising-edge clock
//  resetn         in   1       asynchronous, active-low reset
//  run            in   1       1 = fetch and issue; 0 = stop issuing at next boundary
//  redirect       in   1       1-cycle pulse: restart fetch at redirect_addr
//  redirect_addr  in   ADDR_W  new fetch address
//  mem_req        out  1       read request to program memory
//  mem_addr       out  ADDR_W  read address, valid while mem_req=1
//  mem_ack        in   1       memory completed request; mem_rdata valid this cycle
//  mem_rdata      in   16      instruction word
//  instruction    out  16      instruction register to control unit
//  instr_valid    out  1       instruction holds a live (issued) instruction
//  pc             out  ADDR_W  address of instruction in the instruction register
//  cu_hold        out  1       registered; 1 = keep control unit in reset (state 00)
// BEHAVIOUR
//  Reset (async): mem_req=0, mem_addr=START_ADDR, instruction=16'h0000, instr_valid=0, pc=START_ADDR, cu_hold=1.
//    Also phase=0, FIFO empty, no request outstanding, discard flag=0. Reset mid-handshake abandons the request.
//  Memory handshake: one request outstanding max.
//    - Issue when run=1, redirect=0 and (fifo_count + outstanding) < DEPTH.
//    - mem_req and mem_addr stay constant until the cycle mem_ack=1.
//    - Ack cycle: store {mem_rdata, mem_addr} in FIFO, fetch_pc <= fetch_pc+1 (wraps).
//    - mem_req may stay high into the next request cycle (back-to-back) if space remains.
//    - mem_ack while mem_req=0 is ignored.
//  Issue states:
//    HOLD (cu_hold=1, phase=0):
//      - If run=1 and FIFO non-empty: pop into instruction/pc, instr_valid<=1, cu_hold<=0 -> RUN, phase stays 0.
//      - The first un-held cycle is control unit state 00 with the new instruction.
//    RUN (cu_hold=0): phase increments each cycle, 0->1->2->3. At phase 3:
//      - If run=1 and FIFO non-empty: pop into instruction/pc, phase<=0, stay RUN (zero-bubble issue).
//      - Else: cu_hold<=1, instr_valid<=0, phase<=0, instruction/pc unchanged -> HOLD.
//  instruction never changes except at a pop; it is stable through all four phases.
//  Pop and push in the same cycle are allowed (count unchanged); push never hits a full FIFO (slot reserved at issue).
//  Empty FIFO at boundary: hold, never issue stale/garbage words.
//  redirect=1 (priority over push and pop-refill):
//    - Clear FIFO; fetch_pc <= redirect_addr.
//    - If a request is outstanding and mem_ack=0, set discard: its eventual ack data is dropped and clears discard.
//    - Ack in the redirect cycle is dropped.
//    - No new request in the redirect cycle.
//    - The instruction in execution completes unaffected.
//    - A pop scheduled in the same cycle is suppressed: at phase 3 it goes to HOLD.
//  run=0: no new requests; an outstanding request still completes into the FIFO (unless discarded).
//    The current instruction finishes, then HOLD.
//  Width: fetch_pc ADDR_W bits, 2**ADDR_W-1 + 1 -> 0. FIFO pointers wrap modulo DEPTH. count is 0..DEPTH.
// TESTING
//  1. Reset, run=1, ack 1 cycle after req, mem[0..2]=16'hA000,16'h2400,16'h8800:
//     - Control unit state-00 cycles see instruction A000, 2400, 8800 at 4-cycle spacing.
//     - pc 0,1,2; cu_hold drops once, then stays 0.
//  2. Ack latency 7 cycles: cu_hold=1 for 3 cycles between instructions; phase=0; instruction unchanged while held.
//  3. Ack same cycle as req:
//     - After 2 words buffered plus in-flight, mem_req=0 until the phase-3 pop.
//     - Then req resumes at next address; FIFO count never exceeds 2.
//  4. redirect to 8'h40 while req to addr 5 outstanding:
//     - Ack of addr 5 discarded; next req mem_addr=8'h40.
//     - After current instruction, HOLD, then issue word@0x40 with pc=0x40.
//  5. run=0 at phase 1: current instruction completes; at phase 3 cu_hold<=1, instr_valid<=0; no further mem_req.
//  6. resetn low mid-handshake (mem_req=1): all outputs to reset values immediately; fetch restarts at START_ADDR.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the control unit. Fetches 16-bit instruction words from program
// memory over a single-outstanding req/ack handshake, buffers them in a small
// prefetch FIFO, and presents one instruction to the control unit. That
// instruction stays stable for the control unit's 4-cycle execute sequence
// (states 00..11), which is mirrored here by a 2-bit phase counter.
//
// cu_hold is combined by the core into the control unit reset
// (core_resetn = resetn & ~cu_hold). This parks the control unit in state 00
// whenever no instruction is ready. The first cycle with cu_hold=0 is
// therefore state 00 of the instruction just loaded.
//
// Ports
//   clock          in   1       rising-edge clock
//   resetn         in   1       asynchronous, active-low reset
//   run            in   1       1 = fetch and issue; 0 = stop issuing at next boundary
//   redirect       in   1       one-cycle pulse: flush and restart fetch at redirect_addr
//   redirect_addr  in   ADDR_W  new fetch address
//   mem_req        out  1       program memory read request
//   mem_addr       out  ADDR_W  read address, valid while mem_req=1
//   mem_ack        in   1       memory completes the request; mem_rdata valid this cycle
//   mem_rdata      in   16      instruction word from memory
//   instruction    out  16      instruction register driving the control unit
//   instr_valid    out  1       instruction holds a live (issued) instruction
//   pc             out  ADDR_W  address of the word in the instruction register
//   cu_hold        out  1       registered; 1 = keep the control unit in reset
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              cu_hold
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  // HOLD: control unit held in reset, waiting for a word.
  // RUN : control unit stepping through phases 0..3 of the current word.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } issue_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fetch_pc;   // address of the next word to request
  logic              discard;    // outstanding request belongs to a flushed stream

  logic [15:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  issue_state_e      state;
  logic [1:0]        phase;

  // ---------------------------------------------------------------------------
  // Decode of the current cycle
  // ---------------------------------------------------------------------------
  logic              ack_seen;     // an ack that completes our request
  logic              req_waiting;  // request still in flight after this cycle
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              at_boundary;
  logic [CNT_W:0]    slots_used;
  logic              start_req;
  logic [ADDR_W-1:0] fetch_pc_next;

  // An ack with mem_req low is not ours and is ignored.
  assign ack_seen    = mem_req & mem_ack;
  assign req_waiting = mem_req & ~mem_ack;

  // Data from a flushed stream, or arriving in the redirect cycle itself,
  // never enters the FIFO.
  assign push = ack_seen & ~discard & ~redirect;

  assign fifo_empty  = (count == '0);
  assign at_boundary = (state == ST_HOLD) || (phase == 2'd3);

  // Redirect suppresses a refill scheduled for the same cycle; the FIFO is
  // being flushed so its head is stale.
  assign pop = at_boundary & run & ~redirect & ~fifo_empty;

  // A slot is reserved when a request is launched. Counting the request in
  // flight here (even in its ack cycle) guarantees a push never finds the
  // FIFO full.
  assign slots_used = {1'b0, count} + {{CNT_W{1'b0}}, mem_req};
  assign start_req  = run & ~redirect & (slots_used < (CNT_W + 1)'(DEPTH));

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect) begin
      fetch_pc_next = redirect_addr;
    end else if (ack_seen && !discard) begin
      fetch_pc_next = fetch_pc + ADDR_W'(1);  // wraps modulo 2**ADDR_W
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request channel
  // ---------------------------------------------------------------------------
  // mem_req/mem_addr are frozen while a request waits for its ack. In the ack
  // cycle a follow-on request may be launched straight away, so mem_req can
  // stay high across back-to-back transfers while mem_addr advances.
  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_req  <= 1'b0;
      mem_addr <= START_PC;
      fetch_pc <= START_PC;
      discard  <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_next;
      if (req_waiting) begin
        // A redirect cannot cancel a request memory has already accepted;
        // mark it so its data is dropped when the ack finally arrives.
        discard <= discard | redirect;
      end else begin
        mem_req <= start_req;
        discard <= 1'b0;
        if (start_req) begin
          mem_addr <= fetch_pc_next;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Occupancy is tracked by the reset
  // pointers and count, so an entry is never read before it has been written.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_addr[wr_ptr] <= mem_addr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;  // idle, or push and pop cancel out
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue sequencer
  // ---------------------------------------------------------------------------
  // The instruction register changes only on a pop, so it is stable through
  // all four phases and through any HOLD period that follows. A pop at phase 3
  // chains directly into phase 0 of the next word with no bubble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_HOLD;
      phase       <= 2'd0;
      instruction <= 16'h0000;
      pc          <= START_PC;
      instr_valid <= 1'b0;
      cu_hold     <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (pop) begin
            instruction <= fifo_data[rd_ptr];
            pc          <= fifo_addr[rd_ptr];
            instr_valid <= 1'b1;
            cu_hold     <= 1'b0;
            phase       <= 2'd0;
            state       <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (phase == 2'd3) begin
            phase <= 2'd0;
            if (pop) begin
              instruction <= fifo_data[rd_ptr];
              pc          <= fifo_addr[rd_ptr];
            end else begin
              // Nothing ready (or run dropped, or a redirect flushed the
              // FIFO): park the control unit at state 00.
              instr_valid <= 1'b0;
              cu_hold     <= 1'b1;
              state       <= ST_HOLD;
            end
          end else begin
            phase <= phase + 2'd1;
          end
        end

        default: begin
          state   <= ST_HOLD;
          phase   <= 2'd0;
          cu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule
